// File: rtl/snn_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module : snn_mac_pkg
// Brief  : Shared constants and FSM state encoding for the synapse MAC path.
// Rev    : 1.0 - initial release
// ============================================================================
package snn_mac_pkg;

  localparam int MAC_LANES = 4;
  localparam int WEIGHT_W  = 32;
  localparam int WORD_W    = MAC_LANES * WEIGHT_W;  // 128-bit weight word

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage : snn_mac_pkg
`default_nettype wire

// File: rtl/snn_mac.sv
`default_nettype none
// ============================================================================
// Module : snn_mac
// Brief  : Combinational 4-lane spike MAC. Sums the 32-bit weight lanes whose
//          spike bit is set; the sum wraps modulo 2^32.
// Rev    : 1.0 - initial release
// ============================================================================
module snn_mac
  import snn_mac_pkg::*;
(
  input  logic [MAC_LANES-1:0] spike_in,
  input  logic [WORD_W-1:0]    weight,
  output logic [WEIGHT_W-1:0]  result
);

  // Gate each lane by its spike bit and add; carries out of bit 31 are dropped
  always_comb begin
    result = '0;
    for (int i = 0; i < MAC_LANES; i++) begin
      if (spike_in[i]) begin
        result = result + weight[i*WEIGHT_W +: WEIGHT_W];
      end
    end
  end

endmodule : snn_mac
`default_nettype wire

// File: rtl/synapse_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : synapse_mac_sequencer
// Brief  : Walks a latched spike vector in 4-synapse groups, reads each active
//          group's weight word, feeds the MAC and accumulates a 32-bit sum.
//          All-zero groups are skipped without a memory read.
// Rev    : 1.0 - initial release
// ============================================================================
module synapse_mac_sequencer
  import snn_mac_pkg::*;
#(
  parameter int NUM_SYN = 16,
  parameter int ADDR_W  = ((NUM_SYN / 4) > 1) ? $clog2(NUM_SYN / 4) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [NUM_SYN-1:0]  spike_vec,
  output logic                busy,
  output logic                wmem_rd_en,
  output logic [ADDR_W-1:0]   wmem_addr,
  input  logic [WORD_W-1:0]   wmem_rdata,
  output logic [WEIGHT_W-1:0] sum_out,
  output logic                sum_valid,
  input  logic                sum_ready
);

  localparam int                NUM_GRP  = NUM_SYN / 4;
  localparam logic [ADDR_W-1:0] LAST_GRP = ADDR_W'(NUM_GRP - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     grp_q, grp_d;
  logic [NUM_SYN-1:0]    spk_q, spk_d;
  logic [WEIGHT_W-1:0]   acc_q, acc_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [WEIGHT_W-1:0]   sum_q, sum_d;

  logic [MAC_LANES-1:0]  cur_nib;
  logic [MAC_LANES-1:0]  nxt_nib;
  logic [WEIGHT_W-1:0]   mac_result;

  // Spike nibble of the group currently being processed
  assign cur_nib = spk_q[{grp_q, 2'b00} +: MAC_LANES];

  snn_mac u_mac (
    .spike_in (cur_nib),
    .weight   (wmem_rdata),
    .result   (mac_result)
  );

  // Next-state, datapath and look-ahead output computation
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    spk_d   = spk_q;
    acc_d   = acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          spk_d   = spike_vec;
          acc_d   = '0;
          grp_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // A nonzero nibble had its read issued on entry; wait for the data
        if (cur_nib != '0) begin
          state_d = S_ACCUM;
        end else if (grp_q == LAST_GRP) begin
          state_d = S_DONE;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + mac_result;
        if (grp_q == LAST_GRP) begin
          state_d = S_DONE;
        end else begin
          grp_d   = grp_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (sum_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so decode them from the upcoming state. The read
    // strobe is raised for the whole FETCH cycle of an active group so the
    // word arrives exactly when ACCUM consumes it.
    nxt_nib = spk_d[{grp_d, 2'b00} +: MAC_LANES];
    rd_en_d = (state_d == S_FETCH) && (nxt_nib != '0);
    addr_d  = rd_en_d ? grp_d : addr_q;
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
    sum_d   = (state_d == S_DONE) ? acc_d : '0;
  end

  // State and output registers; reset aborts any pass immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      spk_q   <= '0;
      acc_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      spk_q   <= spk_d;
      acc_q   <= acc_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
    end
  end

  assign busy       = busy_q;
  assign wmem_rd_en = rd_en_q;
  assign wmem_addr  = addr_q;
  assign sum_valid  = valid_q;
  assign sum_out    = sum_q;

endmodule : synapse_mac_sequencer
`default_nettype wire
